wide_add_seq: RTL and testbench
===============================

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter WORDS, default 4: number of 3-bit chunks; operand width W = 3*WORDS (12 at default).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1: operand request valid.
REQ-005 SHALL have port in_ready, output, 1: block can accept operands.
REQ-006 SHALL have ports op_a and op_b, input, W each: unsigned operands.
REQ-007 SHALL have port op_cin, input, 1: carry-in of the wide add.
REQ-008 SHALL have ports add_a and add_b, output, 3 each: chunk operands driven to the external 3-bit full adder.
REQ-009 SHALL have port add_cin, output, 1: carry driven to the external adder.
REQ-010 SHALL have ports add_sum, input, 3 and add_cout, input, 3: adder results; add_cout[2] is the chunk carry-out.
REQ-011 SHALL have port out_valid, output, 1: result valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-013 SHALL have ports res_sum, output, W and res_cout, output, 1: wide sum and final carry.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-015 In IDLE: in_ready=1; on in_valid at a rising edge, latch op_a, op_b, carry reg <= op_cin, index <= 0, go to RUN.
REQ-016 In RUN: add_a/add_b = chunk[index] of the latched operands (chunk i = bits 3i+2:3i, LSB chunk first); add_cin = carry reg.
REQ-017 Each RUN edge: res_sum chunk[index] <= add_sum, carry reg <= add_cout[2], index <= index+1.
REQ-018 On the RUN edge with index = WORDS-1: res_cout <= add_cout[2]; go to DONE.
REQ-019 Latency: out_valid SHALL rise exactly WORDS edges after the accepting edge (4 at default).
REQ-020 In DONE: out_valid=1; res_sum and res_cout held stable; return to IDLE on the edge where out_ready=1.
REQ-021 in_ready SHALL be 0 in RUN and DONE; in_valid in those states is ignored, not queued.
REQ-022 add_a, add_b and add_cin SHALL be 0 outside RUN.
REQ-023 out_valid and out_ready high on the same edge in DONE: result consumed; in_ready rises the next cycle (no same-cycle re-accept).
REQ-024 Index SHALL be ceil(log2(WORDS)) bits minimum and never exceed WORDS-1.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, in_ready=1, out_valid=0, res_sum=0, res_cout=0, carry reg=0, index=0, latched operands=0.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation; no partial result is ever presented.
REQ-027 After rst_n deassertion, the first accept happens no earlier than the first rising edge with rst_n high.

Configuration
REQ-028 With macro WIDE_ADD_OVF_EN defined: extra output port res_ovf, 1 bit = add_cout[2] XOR add_cout[1] captured on the last RUN edge (two's-complement overflow); reset 0; held in DONE.
REQ-029 Without WIDE_ADD_OVF_EN: port res_ovf absent; all other behaviour identical.

Verification
REQ-030 WORDS=4, op_a=0x5A3, op_b=0x2C7, op_cin=0 -> res_sum=0x86A, res_cout=0, out_valid 4 edges after accept.
REQ-031 op_a=0xFFF, op_b=0x001, op_cin=0 -> res_sum=0x000, res_cout=1; carry ripples through all 4 chunks (add_cin=1 in chunks 1-3).
REQ-032 op_a=0x5A3, op_b=0x2C7, op_cin=1 -> res_sum=0x86B; out_ready held low 10 cycles -> out_valid and result stable, in_ready=0 throughout.
REQ-033 rst_n pulsed low after 2 RUN edges -> out_valid=0, res_sum=0 immediately; next request 0x001+0x001 yields 0x002.
REQ-034 WIDE_ADD_OVF_EN defined: 0x7FF+0x001 -> res_sum=0x800, res_ovf=1, res_cout=0; 0xFFF+0x001 -> res_ovf=0.
REQ-035 Back-to-back: in_valid held high with out_ready=1 -> results accepted every WORDS+2 cycles, each correct, none dropped.

Source files
------------

// File: rtl/wide_add_seq_if.sv
// rtl/wide_add_seq_if.sv - operand/result handshake and external adder bus for wide_add_seq
//
// Purpose : bundles the request handshake, the chunk bus to the external
//           3-bit full adder, and the result handshake of wide_add_seq.
// Params  : WORDS - number of 3-bit chunks, operand width W = 3*WORDS.
// Signals : in_valid/in_ready, op_a/op_b/op_cin  - operand request
//           add_a/add_b/add_cin                   - chunk operands to the adder
//           add_sum/add_cout                      - adder results (add_cout[2] = chunk carry-out)
//           out_valid/out_ready, res_sum/res_cout - result handshake
//           res_ovf                               - only with WIDE_ADD_OVF_EN defined
// Modports: master - environment side (requester, consumer and adder)
//           slave  - wide_add_seq side

interface wide_add_seq_if #(
    parameter int WORDS = 4
);
    localparam int W = 3 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic [2:0]   add_a;
    logic [2:0]   add_b;
    logic         add_cin;
    logic [2:0]   add_sum;
    logic [2:0]   add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
`ifdef WIDE_ADD_OVF_EN
    logic         res_ovf;
`endif

    modport master (
        output in_valid, op_a, op_b, op_cin, add_sum, add_cout, out_ready,
`ifdef WIDE_ADD_OVF_EN
        input  res_ovf,
`endif
        input  in_ready, add_a, add_b, add_cin, out_valid, res_sum, res_cout
    );

    modport slave (
        input  in_valid, op_a, op_b, op_cin, add_sum, add_cout, out_ready,
`ifdef WIDE_ADD_OVF_EN
        output res_ovf,
`endif
        output in_ready, add_a, add_b, add_cin, out_valid, res_sum, res_cout
    );
endinterface

// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - sequential wide adder built on an external 3-bit full adder
//
// Purpose : adds two W-bit unsigned operands (W = 3*WORDS) plus a carry-in by
//           feeding one 3-bit chunk per cycle, LSB chunk first, through an
//           external 3-bit full adder. The result is presented WORDS edges
//           after the operands are accepted and held until consumed.
// Params  : WORDS - number of 3-bit chunks (default 4, W = 12).
// Ports   : clk   - clock, all state changes on the rising edge
//           rst_n - asynchronous active-low reset
//           bus   - wide_add_seq_if.slave: request handshake, adder bus,
//                   result handshake (see wide_add_seq_if.sv)
// Option  : WIDE_ADD_OVF_EN - adds res_ovf, the two's-complement overflow
//           (add_cout[2] ^ add_cout[1] of the last chunk), held with the result.

module wide_add_seq #(
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    wide_add_seq_if.slave bus
);
    localparam int W  = 3 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          carry_q;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  res_sum_q;
    logic          res_cout_q;

    logic          in_ready_c;
    logic          out_valid_c;
    logic          run_c;
    logic          last_c;
    logic          accept_c;
    logic [2:0]    chunk_a_c;
    logic [2:0]    chunk_b_c;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        run_c       = 1'b0;
        last_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                run_c = 1'b1;
                if (idx_q == LAST_IDX) begin
                    last_c  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid_c = 1'b1;
                // Returning to IDLE here means in_ready only rises on the
                // following cycle, so a result is never swapped for a new
                // request on the same edge.
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign accept_c = in_ready_c && bus.in_valid;

    // ------------------------------------------------------------------
    // Chunk select for the external adder
    // ------------------------------------------------------------------
    always_comb begin
        chunk_a_c = 3'd0;
        chunk_b_c = 3'd0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IW'(i)) begin
                chunk_a_c = a_q[3*i +: 3];
                chunk_b_c = b_q[3*i +: 3];
            end
        end
    end

    // The adder bus is quiet outside RUN so the external adder never sees
    // stale operands.
    assign bus.add_a   = run_c ? chunk_a_c : 3'd0;
    assign bus.add_b   = run_c ? chunk_b_c : 3'd0;
    assign bus.add_cin = run_c ? carry_q   : 1'b0;

    // ------------------------------------------------------------------
    // Datapath: operand latch, ripple carry, result accumulation
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
        end else if (accept_c) begin
            a_q     <= bus.op_a;
            b_q     <= bus.op_b;
            carry_q <= bus.op_cin;
            idx_q   <= '0;
        end else if (run_c) begin
            for (int i = 0; i < WORDS; i++) begin
                if (idx_q == IW'(i)) begin
                    res_sum_q[3*i +: 3] <= bus.add_sum;
                end
            end
            carry_q <= bus.add_cout[2];
            if (last_c) begin
                res_cout_q <= bus.add_cout[2];
                // Park the index at 0 so it never counts past WORDS-1,
                // whether or not WORDS is a power of two.
                idx_q      <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_cout  = res_cout_q;

`ifdef WIDE_ADD_OVF_EN
    // ------------------------------------------------------------------
    // Signed overflow: carry into the MSB differs from carry out of it
    // ------------------------------------------------------------------
    logic res_ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_ovf_q <= 1'b0;
        end else if (run_c && last_c) begin
            res_ovf_q <= bus.add_cout[2] ^ bus.add_cout[1];
        end
    end

    assign bus.res_ovf = res_ovf_q;
`else
    // Per-bit carries below the chunk carry-out only matter for overflow.
    logic unused_cout_bits;
    assign unused_cout_bits = ^bus.add_cout[1:0];
`endif

endmodule

// File: tb/tb_wide_add_seq.sv
// tb/tb_wide_add_seq.sv - self-checking bench for wide_add_seq with an arithmetic reference model

module tb_wide_add_seq;
    localparam int WORDS = 4;
    localparam int W     = 3 * WORDS;
    localparam int WMASK = (1 << W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    wide_add_seq_if #(.WORDS(WORDS)) bus ();

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // External 3-bit full adder: plain integer addition per bit prefix.
    int t0, t1, t2;
    always_comb begin
        t0 = int'(bus.add_a[0])   + int'(bus.add_b[0])   + int'(bus.add_cin);
        t1 = int'(bus.add_a[1:0]) + int'(bus.add_b[1:0]) + int'(bus.add_cin);
        t2 = int'(bus.add_a)      + int'(bus.add_b)      + int'(bus.add_cin);
        bus.add_sum     = 3'(t2);
        bus.add_cout[0] = t0 >= 2;
        bus.add_cout[1] = t1 >= 4;
        bus.add_cout[2] = t2 >= 8;
    end

    // Reference model: phase 0 idle, 1 busy, 2 result presented.
    int m_phase = 0;
    int m_left  = 0;
    int m_a = 0, m_b = 0, m_cin = 0;
    int m_sum = 0, m_cout = 0, m_ovf = 0;
    bit m_clear = 1'b1;
    int m_full, m_low;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_clear = 1'b1;
            m_sum   = 0;
            m_cout  = 0;
            m_ovf   = 0;
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    m_a     = int'(bus.op_a);
                    m_b     = int'(bus.op_b);
                    m_cin   = int'(bus.op_cin);
                    m_left  = WORDS;
                    m_phase = 1;
                    m_clear = 1'b0;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_full  = m_a + m_b + m_cin;
                        m_sum   = m_full & WMASK;
                        m_cout  = m_full >> W;
                        m_low   = (m_a & (WMASK >> 1)) + (m_b & (WMASK >> 1)) + m_cin;
                        m_ovf   = (m_low >> (W - 1)) ^ m_cout;
                        m_phase = 2;
                    end
                end
                default: if (bus.out_ready) m_phase = 0;
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    bit [WORDS-1:0] cin_trace;
    bit b2b       = 1'b0;
    int last_cons = -1;
    int b2b_count = 0;
    int c_idx, c_mask;

    // Per-cycle compare against the model, sampled away from the rising edge.
    always @(negedge clk) begin
        chk("in_ready", int'(bus.in_ready), int'(m_phase == 0));
        chk("out_valid", int'(bus.out_valid), int'(m_phase == 2));
        if (m_phase == 2) begin
            chk("res_sum", int'(bus.res_sum), m_sum);
            chk("res_cout", int'(bus.res_cout), m_cout);
`ifdef WIDE_ADD_OVF_EN
            chk("res_ovf", int'(bus.res_ovf), m_ovf);
`endif
        end
        if (m_clear) begin
            chk("res_sum_clear", int'(bus.res_sum), 0);
            chk("res_cout_clear", int'(bus.res_cout), 0);
        end
        if (m_phase == 1) begin
            c_idx  = WORDS - m_left;
            c_mask = (1 << (3 * c_idx)) - 1;
            chk("add_a", int'(bus.add_a), (m_a >> (3 * c_idx)) & 7);
            chk("add_b", int'(bus.add_b), (m_b >> (3 * c_idx)) & 7);
            chk("add_cin", int'(bus.add_cin),
                (((m_a & c_mask) + (m_b & c_mask) + m_cin) >> (3 * c_idx)) & 1);
            cin_trace[c_idx] = bus.add_cin;
        end else begin
            chk("add_idle", int'({bus.add_a, bus.add_b, bus.add_cin}), 0);
        end
        if (m_phase == 2 && bus.out_ready && b2b) begin
            if (last_cons >= 0) chk("b2b_spacing", cyc - last_cons, WORDS + 2);
            last_cons = cyc;
            b2b_count++;
        end
    end

    task automatic do_op(input int a, input int b, input int cin,
                         input int exp_s, input int exp_c, input int exp_o,
                         input int hold, input bit noise);
        int lat;
        @(negedge clk);
        bus.op_a     = W'(a);
        bus.op_b     = W'(b);
        bus.op_cin   = cin[0];
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!bus.out_valid && lat < 20);
        chk("latency", lat, WORDS);
        chk("lit_sum", int'(bus.res_sum), exp_s);
        chk("lit_cout", int'(bus.res_cout), exp_c);
`ifdef WIDE_ADD_OVF_EN
        chk("lit_ovf", int'(bus.res_ovf), exp_o);
`else
        if (exp_o < 0) chk("lit_ovf_arg", exp_o, 0);
`endif
        if (noise) begin
            bus.op_a     = W'(~a);
            bus.op_b     = W'(~b);
            bus.in_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_in_ready", int'(bus.in_ready), 0);
            chk("hold_out_valid", int'(bus.out_valid), 1);
            chk("hold_sum", int'(bus.res_sum), exp_s);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("consumed_out_valid", int'(bus.out_valid), 0);
        chk("consumed_in_ready", int'(bus.in_ready), 1);
    endtask

    int b2b_a[5]   = '{'h123, 'hFFF, 'h800, 'h000, 'hABC};
    int b2b_b[5]   = '{'h456, 'hFFF, 'h800, 'h000, 'h543};
    int b2b_cin[5] = '{0, 1, 0, 1, 1};

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_cin    = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_sum", int'(bus.res_sum), 0);
        chk("rst_cout", int'(bus.res_cout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op('h5A3, 'h2C7, 0, 'h86A, 0, 0, 0, 1'b0);
        do_op('hFFF, 'h001, 0, 'h000, 1, 0, 0, 1'b0);
        chk("ripple_cin", int'(cin_trace), 'b1110);
        do_op('h5A3, 'h2C7, 1, 'h86B, 0, 0, 10, 1'b1);

        // Abort mid-operation with an asynchronous reset pulse.
        @(negedge clk);
        bus.op_a     = W'('h5A3);
        bus.op_b     = W'('h2C7);
        bus.op_cin   = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(bus.out_valid), 0);
        chk("abort_sum", int'(bus.res_sum), 0);
        chk("abort_in_ready", int'(bus.in_ready), 1);
        #1 rst_n = 1'b1;
        do_op('h001, 'h001, 0, 'h002, 0, 0, 0, 1'b0);

`ifdef WIDE_ADD_OVF_EN
        do_op('h7FF, 'h001, 0, 'h800, 0, 1, 0, 1'b0);
        do_op('hFFF, 'h001, 0, 'h000, 1, 0, 0, 1'b0);
`endif

        // Back-to-back stream with the consumer always ready.
        b2b           = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.op_a   = W'(b2b_a[k]);
            bus.op_b   = W'(b2b_b[k]);
            bus.op_cin = b2b_cin[k][0];
            n = 0;
            while (!bus.in_ready && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 50) chk("b2b_accept_timeout", n, 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (b2b_count < 5 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b2b_count", b2b_count, 5);
        bus.out_ready = 1'b0;
        b2b = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
